// File: rtl/oam_access_arbiter.sv
// OAM port arbiter: PPU sprite reads share the single-port OAM with CPU
// stores, which are posted into a small in-order write FIFO. Reads win the
// port unless vblank is active or the FIFO head has waited too long.
module oam_access_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_oam_we,
    input  logic [ADDR_W-1:0]               cpu_oam_addr,
    input  logic [DATA_W-1:0]               cpu_oam_wdata,
    output logic                            cpu_stall,
    input  logic                            vblank,
    input  logic                            ppu_rd_req,
    input  logic [ADDR_W-1:0]               ppu_rd_addr,
    output logic                            ppu_rd_gnt,
    output logic                            ppu_rd_valid,
    output logic [DATA_W-1:0]               ppu_rd_data,
    output logic                            oam_en,
    output logic                            oam_we,
    output logic [ADDR_W-1:0]               oam_addr,
    output logic [DATA_W-1:0]               oam_wdata,
    input  logic [DATA_W-1:0]               oam_rdata,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_RELOAD = STV_W'(STARVE_LIM - 1);

    // Port owner for the current cycle, listed in priority order.
    typedef enum logic [2:0] {
        SEL_IDLE,
        SEL_FORCE,
        SEL_VBLANK,
        SEL_PPU,
        SEL_DRAIN
    } sel_e;

    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    // Down-counter of cycles the head may still wait; terminal count 0
    // corresponds to STARVE_LIM-1 consecutive undrained cycles.
    logic [STV_W-1:0]  starve_left;

    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    sel_e              sel;
    logic              fifo_empty;
    logic              starved;
    logic              push;
    logic              pop;

    assign fifo_empty = (count_q == '0);
    assign starved    = !fifo_empty && (starve_left == '0);
    assign cpu_stall  = cpu_oam_we && (count_q == FULL_CNT);
    assign push       = cpu_oam_we && !cpu_stall;
    assign fifo_count = count_q;

    // Choose the port owner; no OAM access is issued while in reset.
    always_comb begin
        sel = SEL_IDLE;
        if (rst) begin
            sel = SEL_IDLE;
        end else if (starved) begin
            sel = SEL_FORCE;
        end else if (vblank && !fifo_empty) begin
            sel = SEL_VBLANK;
        end else if (ppu_rd_req) begin
            sel = SEL_PPU;
        end else if (!fifo_empty) begin
            sel = SEL_DRAIN;
        end
    end

    // Drive the OAM port, PPU grant and FIFO pop from the selected owner.
    always_comb begin
        oam_en     = 1'b0;
        oam_we     = 1'b0;
        oam_addr   = '0;
        oam_wdata  = '0;
        ppu_rd_gnt = 1'b0;
        pop        = 1'b0;
        case (sel)
            SEL_FORCE, SEL_VBLANK, SEL_DRAIN: begin
                oam_en    = 1'b1;
                oam_we    = 1'b1;
                oam_addr  = addr_mem[rd_ptr];
                oam_wdata = data_mem[rd_ptr];
                pop       = 1'b1;
            end
            SEL_PPU: begin
                oam_en     = 1'b1;
                oam_addr   = ppu_rd_addr;
                ppu_rd_gnt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Posted-write FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= cpu_oam_addr;
                data_mem[wr_ptr] <= cpu_oam_wdata;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Anti-starvation timer: reload on pop or empty FIFO, else count down to 0.
    always_ff @(posedge clk) begin
        if (rst || pop || fifo_empty) begin
            starve_left <= STV_RELOAD;
        end else if (starve_left != '0) begin
            starve_left <= starve_left - 1'b1;
        end
    end

    // Read return: valid one cycle after grant, data held until the next valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= ppu_rd_gnt;
            if (rd_valid_q) begin
                rd_data_q <= oam_rdata;
            end
        end
    end

    // RAM output is live during the valid cycle; the register holds it after.
    assign ppu_rd_valid = rd_valid_q;
    assign ppu_rd_data  = rd_valid_q ? oam_rdata : rd_data_q;

endmodule

// File: tb/tb_oam_access_arbiter.sv
// Directed bench for oam_access_arbiter with a behavioural OAM and
// scoreboards for committed writes and returned read data.
module tb_oam_access_arbiter;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_LIM = 8;
    localparam int CNT_W      = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_oam_we;
    logic [ADDR_W-1:0] cpu_oam_addr;
    logic [DATA_W-1:0] cpu_oam_wdata;
    logic              cpu_stall;
    logic              vblank;
    logic              ppu_rd_req;
    logic [ADDR_W-1:0] ppu_rd_addr;
    logic              ppu_rd_gnt;
    logic              ppu_rd_valid;
    logic [DATA_W-1:0] ppu_rd_data;
    logic              oam_en;
    logic              oam_we;
    logic [ADDR_W-1:0] oam_addr;
    logic [DATA_W-1:0] oam_wdata;
    logic [DATA_W-1:0] oam_rdata = '0;
    logic [CNT_W-1:0]  fifo_count;

    logic [DATA_W-1:0] ram     [64] = '{default: '0};
    logic [DATA_W-1:0] ref_mem [64] = '{default: '0};

    logic [ADDR_W+DATA_W-1:0] wq [$];
    logic [DATA_W-1:0]        rdq [$];
    logic [ADDR_W+DATA_W-1:0] wexp;
    logic [DATA_W-1:0]        rexp;

    int n_checks = 0;
    int n_fail   = 0;

    oam_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_oam_we(cpu_oam_we), .cpu_oam_addr(cpu_oam_addr),
        .cpu_oam_wdata(cpu_oam_wdata), .cpu_stall(cpu_stall),
        .vblank(vblank),
        .ppu_rd_req(ppu_rd_req), .ppu_rd_addr(ppu_rd_addr),
        .ppu_rd_gnt(ppu_rd_gnt), .ppu_rd_valid(ppu_rd_valid),
        .ppu_rd_data(ppu_rd_data),
        .oam_en(oam_en), .oam_we(oam_we), .oam_addr(oam_addr),
        .oam_wdata(oam_wdata), .oam_rdata(oam_rdata),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Single-port OAM with registered read data.
    always @(posedge clk) begin
        if (oam_en) begin
            if (oam_we) ram[oam_addr] <= oam_wdata;
            else        oam_rdata     <= ram[oam_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_put(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic exp_stall, input string tag);
        cpu_oam_we    = 1'b1;
        cpu_oam_addr  = a;
        cpu_oam_wdata = d;
        @(negedge clk);
        chk(tag, 64'(cpu_stall), 64'(exp_stall));
        if (!exp_stall) wq.push_back({a, d});
    endtask

    // Scoreboard: OAM writes in issue order, read data against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (oam_we) begin
                chk("we_implies_en", 64'(oam_en), 64'd1);
                chk("write_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    wexp = wq.pop_front();
                    chk("wr_addr", 64'(oam_addr), 64'(wexp[DATA_W +: ADDR_W]));
                    chk("wr_data", 64'(oam_wdata), 64'(wexp[DATA_W-1:0]));
                    ref_mem[wexp[DATA_W +: ADDR_W]] = wexp[DATA_W-1:0];
                end
            end
            if (ppu_rd_valid) begin
                chk("valid_expected", 64'(rdq.size() != 0), 64'd1);
                if (rdq.size() != 0) begin
                    rexp = rdq.pop_front();
                    chk("rd_data", 64'(ppu_rd_data), 64'(rexp));
                end
            end
            if (ppu_rd_gnt) rdq.push_back(ref_mem[ppu_rd_addr]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cpu_oam_we = 1'b0; cpu_oam_addr = '0; cpu_oam_wdata = '0;
        vblank = 1'b0; ppu_rd_req = 1'b0; ppu_rd_addr = '0;

        // Power-on reset
        tick();
        @(negedge clk);
        chk("rst0_count", 64'(fifo_count), 64'd0);
        chk("rst0_en", 64'(oam_en), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_valid", 64'(ppu_rd_valid), 64'd0);
        chk("rst_data", 64'(ppu_rd_data), 64'd0);
        chk("rst_en", 64'(oam_en), 64'd0);
        tick();

        // Reset with three pending writes and a read stream in flight
        ppu_rd_req = 1'b1; ppu_rd_addr = 6'd10;
        cpu_put(6'd20, 32'h1111_0020, 1'b0, "fill0_stall"); tick();
        cpu_put(6'd21, 32'h1111_0021, 1'b0, "fill1_stall"); tick();
        cpu_put(6'd22, 32'h1111_0022, 1'b0, "fill2_stall"); tick();
        cpu_oam_we = 1'b0;
        @(negedge clk);
        chk("fill_count", 64'(fifo_count), 64'd3);
        chk("fill_no_write", 64'(oam_we), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_count", 64'(fifo_count), 64'd0);
        chk("midrst_valid", 64'(ppu_rd_valid), 64'd0);
        tick();
        rst = 1'b0; ppu_rd_req = 1'b0;
        wq.delete(); rdq.delete();
        @(negedge clk);
        chk("postrst_count", 64'(fifo_count), 64'd0);
        chk("postrst_valid", 64'(ppu_rd_valid), 64'd0);
        chk("postrst_en", 64'(oam_en), 64'd0);
        tick();
        @(negedge clk);
        chk("postrst_en2", 64'(oam_en), 64'd0);
        chk("postrst_valid2", 64'(ppu_rd_valid), 64'd0);
        tick();

        // Idle drain, no same-cycle bypass
        cpu_put(6'd5, 32'hDEAD_BEEF, 1'b0, "idle_stall");
        chk("idle_no_bypass", 64'(oam_en), 64'd0);
        tick();
        cpu_oam_we = 1'b0;
        @(negedge clk);
        chk("idle_we", 64'(oam_we), 64'd1);
        chk("idle_addr", 64'(oam_addr), 64'd5);
        chk("idle_wdata", 64'(oam_wdata), 64'hDEAD_BEEF);
        chk("idle_count_pending", 64'(fifo_count), 64'd1);
        tick();
        @(negedge clk);
        chk("idle_count_done", 64'(fifo_count), 64'd0);
        chk("idle_en_off", 64'(oam_en), 64'd0);
        tick();

        // PPU read latency
        ppu_rd_req = 1'b1; ppu_rd_addr = 6'd5;
        @(negedge clk);
        chk("rd_gnt", 64'(ppu_rd_gnt), 64'd1);
        chk("rd_oam_we", 64'(oam_we), 64'd0);
        chk("rd_oam_addr", 64'(oam_addr), 64'd5);
        tick();
        ppu_rd_req = 1'b0;
        @(negedge clk);
        chk("rd_valid", 64'(ppu_rd_valid), 64'd1);
        chk("rd_value", 64'(ppu_rd_data), 64'hDEAD_BEEF);
        tick();
        @(negedge clk);
        chk("rd_valid_pulse", 64'(ppu_rd_valid), 64'd0);
        chk("rd_hold", 64'(ppu_rd_data), 64'hDEAD_BEEF);
        tick();

        // Full FIFO under continuous PPU reads: stall until the forced drain
        ppu_rd_req = 1'b1; ppu_rd_addr = 6'd7;
        begin
            int idx = 0;
            for (int k = 0; k < 10; k++) begin
                logic st;
                st = (k >= 4) && (k <= 8);
                cpu_put(6'(32 + idx), 32'hA000_0000 + 32'(idx), st, "full_stall");
                chk("full_gnt", 64'(ppu_rd_gnt), 64'(k != 8));
                if (k == 8) begin
                    chk("full_force_we", 64'(oam_we), 64'd1);
                    chk("full_force_addr", 64'(oam_addr), 64'd32);
                end
                if (!st) idx++;
                tick();
            end
        end
        cpu_oam_we = 1'b0;
        @(negedge clk);
        chk("full_count", 64'(fifo_count), 64'd4);
        tick();
        ppu_rd_req = 1'b0;
        begin
            int w = 0;
            while (fifo_count != '0 && w < 20) begin
                tick();
                w++;
            end
        end
        chk("full_drained", 64'(fifo_count), 64'd0);

        // Starvation with one pending write
        ppu_rd_req = 1'b1; ppu_rd_addr = 6'd5;
        cpu_put(6'd40, 32'h5A5A_0040, 1'b0, "starve_push");
        chk("starve_gnt0", 64'(ppu_rd_gnt), 64'd1);
        tick();
        cpu_oam_we = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("starve_gnt", 64'(ppu_rd_gnt), 64'(k != 8));
            chk("starve_we", 64'(oam_we), 64'(k == 8));
            tick();
        end

        // Vblank drains ahead of PPU reads, in issue order
        cpu_put(6'd1, 32'hB000_0001, 1'b0, "vb_push1"); tick();
        cpu_put(6'd2, 32'hB000_0002, 1'b0, "vb_push2"); tick();
        cpu_put(6'd3, 32'hB000_0003, 1'b0, "vb_push3"); tick();
        cpu_oam_we = 1'b0; vblank = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("vb_gnt", 64'(ppu_rd_gnt), 64'd0);
            chk("vb_we", 64'(oam_we), 64'd1);
            chk("vb_addr", 64'(oam_addr), 64'(k + 1));
            tick();
        end
        @(negedge clk);
        chk("vb_resume_gnt", 64'(ppu_rd_gnt), 64'd1);
        chk("vb_count", 64'(fifo_count), 64'd0);
        tick();

        ppu_rd_req = 1'b0; vblank = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("end_writes_done", 64'(wq.size()), 64'd0);
        chk("end_reads_done", 64'(rdq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
